pio_led_pwm_ctrl: RTL and testbench



---
 rtl/pio_led_pwm_ctrl.sv | 157 +++++++++++++++
 tb/tb_pio_led_pwm_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_led_pwm_ctrl.sv
// rtl/pio_led_pwm_ctrl.sv - Avalon-MM LED PIO with per-channel direct/PWM/blink modes
module pio_led_pwm_ctrl #(
    parameter int NUM_CH  = 32,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 16,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic                avs_read,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic [NUM_CH-1:0]   pio_led_export,
    output logic                pwm_tick
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_DIRECT = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);

    localparam logic [1:0] M_DIRECT    = 2'd0;
    localparam logic [1:0] M_PWM       = 2'd1;
    localparam logic [1:0] M_BLINK     = 2'd2;
    localparam logic [1:0] M_BLINK_PWM = 2'd3;

    logic                en;
    logic [PRESC_W-1:0]  prescale;
    logic [NUM_CH-1:0]   direct;
    logic [1:0]          mode [NUM_CH];
    logic [PWM_W-1:0]    duty [NUM_CH];

    logic [PRESC_W-1:0]  presc_cnt;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                blink_phase;
    logic                tick;

    logic [NUM_CH-1:0]   ch_wr;
    logic [NUM_CH-1:0]   next_led;
    logic [DATA_W-1:0]   rd_mux;
    logic                unused_wdata;

    // Only the low bits of each register are stored; the rest are ignored.
    assign unused_wdata = ^avs_writedata;

    always_comb begin
        ch_wr = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ch_wr[ch] = avs_write && (avs_address == ADDR_W'(ch + 4));
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            en       <= 1'b0;
            prescale <= '0;
            direct   <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                mode[ch] <= '0;
                duty[ch] <= '0;
            end
        end else begin
            if (avs_write) begin
                case (avs_address)
                    A_CTRL:   en       <= avs_writedata[0];
                    A_PRESC:  prescale <= avs_writedata[PRESC_W-1:0];
                    A_DIRECT: direct   <= avs_writedata[NUM_CH-1:0];
                    default:  ;
                endcase
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (ch_wr[ch]) begin
                    mode[ch] <= avs_writedata[1:0];
                    duty[ch] <= avs_writedata[PWM_W+7:8];
                end
            end
        end
    end

    // Equality-only compare: lowering PRESCALE below the count lets it run to the wrap.
    assign tick     = en && (presc_cnt == prescale);
    assign pwm_tick = tick;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1) begin
                blink_phase <= ~blink_phase;
            end
        end else if (en) begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    always_comb begin
        next_led = pio_led_export;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mode[ch] == M_DIRECT) begin
                next_led[ch] = direct[ch];
            end else if (en) begin
                case (mode[ch])
                    M_PWM:       next_led[ch] = (pwm_cnt < duty[ch]);
                    M_BLINK:     next_led[ch] = blink_phase;
                    M_BLINK_PWM: next_led[ch] = blink_phase && (pwm_cnt < duty[ch]);
                    default:     next_led[ch] = direct[ch];
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pio_led_export <= '0;
        end else begin
            pio_led_export <= next_led;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_CTRL:   rd_mux[0]            = en;
            A_PRESC:  rd_mux[PRESC_W-1:0]  = prescale;
            A_DIRECT: rd_mux[NUM_CH-1:0]   = direct;
            A_STATUS: begin
                rd_mux[PWM_W-1:0] = pwm_cnt;
                rd_mux[16]        = blink_phase;
            end
            default: begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (avs_address == ADDR_W'(ch + 4)) begin
                        rd_mux[1:0]         = mode[ch];
                        rd_mux[PWM_W+7:8]   = duty[ch];
                    end
                end
            end
        endcase
    end

    // Read data is captured from pre-edge state, so a same-cycle write is not visible.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pio_led_pwm_ctrl.sv
// tb/tb_pio_led_pwm_ctrl.sv - self-checking bench for pio_led_pwm_ctrl
module tb_pio_led_pwm_ctrl;

    localparam int NUM_CH  = 8;
    localparam int PWM_W   = 4;
    localparam int PRESC_W = 16;
    localparam int ADDR_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [31:0]       wdata;
    logic              rd;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] led;
    logic              tick;

    always #5 clk = ~clk;

    pio_led_pwm_ctrl #(
        .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESC_W(PRESC_W), .ADDR_W(ADDR_W), .DATA_W(32)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .avs_address(addr),
        .avs_write(wr),
        .avs_writedata(wdata),
        .avs_read(rd),
        .avs_readdata(rdata),
        .pio_led_export(led),
        .pwm_tick(tick)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: PWM position and blink phase derive from the total tick count.
    bit          m_en;
    int          m_presc;
    int          m_pcnt;
    int          m_ticks;
    bit [7:0]    m_direct;
    int          m_mode [NUM_CH];
    int          m_duty [NUM_CH];
    bit [7:0]    m_led;
    bit [31:0]   m_rdata;

    function automatic bit [31:0] model_read(int a);
        bit [31:0] v;
        v = 0;
        if (a == 0) v = {31'd0, m_en};
        else if (a == 1) v = m_presc;
        else if (a == 2) v = {24'd0, m_direct};
        else if (a == 3) v = (m_ticks % 16) + (((m_ticks / 16) % 2) << 16);
        else if (a >= 4 && a < 4 + NUM_CH) v = m_mode[a-4] + (m_duty[a-4] << 8);
        return v;
    endfunction

    task automatic model_reset();
        m_en = 0; m_presc = 0; m_pcnt = 0; m_ticks = 0; m_direct = 0;
        m_led = 0; m_rdata = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0; m_duty[c] = 0;
        end
    endtask

    task automatic step();
        bit tk, blk, on, i_rst, i_wr, i_rd, exp_tick;
        int pwm, a;
        bit [31:0] d, nr;
        bit [7:0] nl;
        i_rst = rst; i_wr = wr; i_rd = rd; a = int'(addr); d = wdata;
        pwm = m_ticks % 16;
        blk = ((m_ticks / 16) % 2) == 1;
        tk  = m_en && (m_pcnt == m_presc);
        nr  = i_rd ? model_read(a) : m_rdata;
        for (int c = 0; c < NUM_CH; c++) begin
            on = pwm < m_duty[c];
            if (m_mode[c] == 0) nl[c] = m_direct[c];
            else if (!m_en) nl[c] = m_led[c];
            else if (m_mode[c] == 1) nl[c] = on;
            else if (m_mode[c] == 2) nl[c] = blk;
            else nl[c] = blk & on;
        end
        @(posedge clk);
        #1;
        if (i_rst) begin
            model_reset();
        end else begin
            m_ticks = m_ticks + int'(tk);
            if (m_en) m_pcnt = tk ? 0 : (m_pcnt + 1) % 65536;
            m_led = nl;
            m_rdata = nr;
            if (i_wr) begin
                if (a == 0) m_en = d[0];
                else if (a == 1) m_presc = int'(d[15:0]);
                else if (a == 2) m_direct = d[7:0];
                else if (a >= 4 && a < 4 + NUM_CH) begin
                    m_mode[a-4] = int'(d[1:0]);
                    m_duty[a-4] = int'(d[11:8]);
                end
            end
        end
        exp_tick = m_en && (m_pcnt == m_presc);
        vectors++;
        if (led !== m_led || rdata !== m_rdata || tick !== exp_tick) begin
            miscompares++;
            $display("FAIL model @%0t: led=%h rdata=%h tick=%b, expected led=%h rdata=%h tick=%b",
                     $time, led, rdata, tick, m_led, m_rdata, exp_tick);
        end
    endtask

    task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idle();
        wr = 0; rd = 0;
        step();
    endtask

    task automatic write(int a, logic [31:0] d);
        addr = ADDR_W'(a); wdata = d; wr = 1; rd = 0;
        step();
        wr = 0;
    endtask

    task automatic read(int a);
        addr = ADDR_W'(a); rd = 1; wr = 0;
        step();
        rd = 0;
    endtask

    typedef struct {
        int          a;
        logic [31:0] d;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t tbl [9];

    initial begin
        int hi, tk, c1, c2;
        bit pv;
        logic [31:0] s1;
        logic [7:0] l1;
        int r, ra;

        tbl[0] = '{1,  32'hFFFF_FFFF, 32'h0000_FFFF};
        tbl[1] = '{2,  32'hFFFF_FF5A, 32'h0000_005A};
        tbl[2] = '{4,  32'hFFFF_FFFF, 32'h0000_0F03};
        tbl[3] = '{11, 32'h1234_5602, 32'h0000_0602};
        tbl[4] = '{12, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[5] = '{63, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[6] = '{3,  32'hFFFF_FFFF, 32'h0000_0000};
        tbl[7] = '{0,  32'hFFFF_FFFE, 32'h0000_0000};
        tbl[8] = '{0,  32'h0000_0001, 32'h0000_0001};

        model_reset();
        rst = 1; addr = 0; wr = 0; wdata = 0; rd = 0;
        step(); step();
        rst = 0;
        check("reset_led", {24'd0, led}, 0);
        check("reset_tick", {31'd0, tick}, 0);
        for (int a = 0; a < 12; a++) begin
            read(a);
            check($sformatf("reset_read_%0d", a), rdata, 0);
        end

        foreach (tbl[i]) begin
            write(tbl[i].a, tbl[i].d);
            read(tbl[i].a);
            check($sformatf("regmap_%0d", i), rdata, tbl[i].exp);
        end
        rst = 1; step(); rst = 0;

        write(2, 32'hA5);
        check("direct_before", {24'd0, led}, 0);
        idle();
        check("direct_after", {24'd0, led}, 32'hA5);
        read(2);
        check("direct_read", rdata, 32'hA5);

        write(1, 0);
        write(4, 32'h0401);
        write(0, 1);
        idle(); idle();
        hi = 0; tk = 0;
        for (int i = 0; i < 16; i++) begin
            idle();
            hi += int'(led[0]); tk += int'(tick);
        end
        check("pwm_duty4_high", hi, 4);
        check("tick_every_cycle", tk, 16);
        write(4, 32'h0001);
        idle(); idle();
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            idle();
            hi += int'(led[0]);
        end
        check("pwm_duty0_high", hi, 0);

        write(1, 2);
        write(5, 32'h2);
        tk = 0;
        for (int i = 0; i < 30; i++) begin
            idle();
            tk += int'(tick);
        end
        check("tick_every_3rd", tk, 10);
        c1 = -1; c2 = -1; pv = led[1];
        for (int i = 0; i < 200 && c2 < 0; i++) begin
            idle();
            if (led[1] !== pv) begin
                pv = led[1];
                if (c1 < 0) c1 = i; else c2 = i;
            end
        end
        check("blink_half_period", c2 - c1, 48);
        read(3);
        check("status_blink_vs_led", {31'd0, rdata[16]}, {31'd0, led[1]});

        write(1, 0);
        write(6, 32'h0803);
        idle(); idle();
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            idle();
            hi += int'(led[2]);
        end
        check("blink_pwm_32", hi, 8);
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            idle();
            hi += int'(led[2]);
        end
        check("blink_pwm_64", hi, 16);

        write(0, 0);
        read(3);
        s1 = rdata; l1 = led;
        for (int i = 0; i < 20; i++) idle();
        read(3);
        check("freeze_status", rdata, s1);
        check("freeze_led", {24'd0, led}, {24'd0, l1});
        write(0, 1);
        for (int i = 0; i < 10; i++) idle();
        rst = 1; step(); rst = 0;
        check("midrun_reset_led", {24'd0, led}, 0);
        check("midrun_reset_rdata", rdata, 0);
        check("midrun_reset_tick", {31'd0, tick}, 0);
        read(3);
        check("midrun_reset_status", rdata, 0);

        for (int i = 0; i < 4000; i++) begin
            r  = $urandom_range(0, 199);
            ra = $urandom_range(0, 15);
            wr = 0; rd = 0; rst = 0;
            addr = ADDR_W'(ra);
            if (r < 30) begin
                wr = 1;
                wdata = (ra == 1) ? 32'($urandom_range(0, 3)) : $urandom;
                if (r < 8) rd = 1;
            end else if (r < 60) begin
                rd = 1;
            end else if (r == 199) begin
                rst = 1;
            end
            step();
        end
        wr = 0; rd = 0; rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
